// File: rtl/bm_param_ring_memory.sv
// Parametrised ring-buffer memory with registered read port, occupancy tracking
// and full/empty/overflow/underflow reporting; OVERWRITE selects drop vs overwrite-oldest.
module bm_param_ring_memory #(
    parameter int unsigned BITS      = 2,
    parameter int unsigned ADDR_BITS = 2,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [BITS-1:0]      value_in,
    input  logic                 rd_en,
    output logic [BITS-1:0]      value_out,
    output logic                 out_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CW    = ADDR_BITS + 1;
    localparam bit          OVW   = (OVERWRITE != 0);

    logic [BITS-1:0]      mem [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [BITS-1:0]      value_out_q, value_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic                 full_c, empty_c;
    logic                 rd_acc_c, wr_acc_c, ovw_c;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == CW'(0));

    // Accept decisions; an overwrite is a write into a full buffer with no read to make room.
    assign rd_acc_c = rd_en & ~empty_c;
    assign wr_acc_c = wr_en & (~full_c | rd_acc_c | OVW);
    assign ovw_c    = wr_en & full_c & ~rd_acc_c & OVW;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        value_out_d = value_out_q;
        out_valid_d = 1'b0;
        overflow_d  = wr_en & full_c & ~rd_acc_c;
        underflow_d = rd_en & empty_c;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        end
        if (rd_acc_c) begin
            value_out_d = mem[rd_ptr_q];
            out_valid_d = 1'b1;
        end
        if (rd_acc_c || ovw_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        end

        // Overwrite leaves occupancy at DEPTH, so it is excluded from the increment.
        unique case ({wr_acc_c & ~ovw_c, rd_acc_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            value_out_q <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            value_out_q <= value_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_acc_c) begin
            mem[wr_ptr_q] <= value_in;
        end
    end

    assign value_out = value_out_q;
    assign out_valid = out_valid_q;
    assign full      = full_c;
    assign empty     = empty_c;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/bm_param_ring_memory.md
# bm_param_ring_memory

Parametrised ring-buffer memory benchmark: a `2**ADDR_BITS`-entry, `BITS`-wide storage array with auto-incrementing write and read address counters. It provides a registered read port, occupancy tracking, full/empty flags and overflow/underflow reporting. A compile-time mode selects between dropping writes when full and overwriting the oldest entry. It sits in the microbenchmark memory set as the scalable, stateful successor to the fixed 4×2-bit single-slot memory tests.

## Interface
- `BITS`, 2, data width of each memory slot (≥1).
- `ADDR_BITS`, 2, address width; `DEPTH = 2**ADDR_BITS` slots (≥1).
- `OVERWRITE`, 0, controls writes when full. 0 drops the write. 1 overwrites the oldest entry.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `wr_en`  in  1  write request this cycle.
- `value_in`  in  `BITS`  write data.
- `rd_en`  in  1  read request this cycle.
- `value_out`  out  `BITS`  registered read data.
- `out_valid`  out  1  one-cycle pulse: `value_out` was updated by an accepted read.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  `ADDR_BITS+1`  number of stored entries, range 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: write requested while full and no read accepted.
- `underflow`  out  1  one-cycle pulse: read requested while empty.

## Operation
- Internal state:
  - `wr_ptr` and `rd_ptr` are `ADDR_BITS` wide.
  - `count` is a register.
  - The memory array is not reset; its contents are undefined after reset.
- Reset values (asynchronous, while `reset_n=0`):
  - `wr_ptr=0`, `rd_ptr=0`, `count=0`
  - `value_out=0`, `out_valid=0`, `overflow=0`, `underflow=0`
  - Derived flags: `empty=1`, `full=0`.
- `full` and `empty` are decoded directly from the `count` register, so they are coherent with `count` every cycle.
- Read accepted (`rd_acc`) = `rd_en & !empty`.
  - On `rd_acc`: `value_out <= mem[rd_ptr]`, `rd_ptr <= rd_ptr+1`, `out_valid <= 1`.
  - Otherwise `value_out` holds its value and `out_valid <= 0`.
- Write accepted (`wr_acc`) = `wr_en & (!full | rd_acc | OVERWRITE)`.
  - On `wr_acc`: `mem[wr_ptr] <= value_in`, `wr_ptr <= wr_ptr+1`.
- Pointers wrap modulo `DEPTH`: `DEPTH-1` goes to 0 with natural binary overflow.
- Count update:
  - `+1` on a write-only accept.
  - `−1` on a read-only accept.
  - Unchanged on both or neither.
  - Unchanged on an overwrite.
- Overwrite case (`OVERWRITE=1`, full, `wr_en`, no `rd_acc`):
  - write at `wr_ptr`;
  - `wr_ptr` and `rd_ptr` both advance;
  - `count` stays `DEPTH`;
  - `overflow` pulses;
  - `value_out` and `out_valid` are unaffected.
- Drop case (`OVERWRITE=0`, full, `wr_en`, no `rd_acc`):
  - memory and pointers are unchanged;
  - `overflow` pulses.
- Full with simultaneous `wr_en` and `rd_en`:
  - both are accepted in either mode;
  - the read returns the oldest entry;
  - `count` stays `DEPTH`;
  - no overflow.
- Empty with simultaneous `wr_en` and `rd_en`:
  - the read is rejected and `underflow` pulses;
  - the write is accepted and `count` becomes 1;
  - there is no write-to-read bypass.
- `rd_en` while empty: `underflow` pulses; all other state holds.
- `wr_en=rd_en=0`: all state holds; pulses deassert.

## Timing
- Writes update memory, `wr_ptr` and `count` on the same rising edge. `full`/`empty` reflect the new `count` immediately after that edge.
- Write-to-read latency:
  - data written at edge k can be read by `rd_en` sampled at edge k+1;
  - `value_out`/`out_valid` are valid after edge k+1.
  - Minimum write-to-data-out latency is 2 edges.
- Read latency is 1 cycle: `rd_en` sampled at edge k gives `value_out` and `out_valid=1` after edge k; `out_valid` drops after edge k+1 unless another read is accepted.
- `overflow` and `underflow` are registered: high for exactly the cycle after the offending edge.
- Back-to-back reads or writes run at one per cycle with no bubbles.
- Reset asserted mid-operation:
  - all registers listed under Operation return to their reset values immediately, without waiting for a clock edge;
  - stored data is logically discarded (`count=0`).
- Deassertion of `reset_n` is assumed synchronous to `clock` by the surrounding bench.

## Test plan
- Reset then idle → `count=0`, `empty=1`, `full=0`, `value_out=0`, `out_valid=0`, and all pulses 0.
- Defaults; write 1,2,3,0 on 4 cycles, then read 4 cycles → `full=1` after the 4th write; `value_out` sequence 1,2,3,0 with `out_valid` high 4 cycles; `empty=1` at end.
- `OVERWRITE=0`, full with 1,2,3,0; write 2 alone → `overflow` pulses once, `count=4`; subsequent reads give 1,2,3,0.
- `OVERWRITE=1`, full with 1,2,3,0; write 2 alone → `overflow` pulses, `count=4`; reads give 2,3,0,2.
- Empty; `wr_en=1` (value 3) with `rd_en=1` → `underflow` pulses, `count=1`, `out_valid=0`; the next-cycle read returns 3.
- `BITS=8`, `ADDR_BITS=3`: 20 interleaved write/read cycles crossing pointer wrap, plus `reset_n` pulsed low mid-burst → output matches a reference queue model; after reset `count=0` and the next read sets `underflow`.
